// File: rtl/max_seq_ctrl.sv
// Frame-maximum controller: accepts N signed 3-bit samples per frame and
// registers the frame maximum plus the index of its first occurrence.

// Shared 3-bit signed maximum selector; b wins only when strictly greater.
module max3_sel (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [2:0] max,
  output logic       b_gt
);
  always_comb begin
    // differing sign bits: the non-negative operand is larger
    if (a[2] != b[2]) b_gt = a[2];
    else              b_gt = (b[1:0] > a[1:0]);
    max = b_gt ? b : a;
  end
endmodule

module max_seq_ctrl #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [2:0] in_data,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  output logic [2:0] max_out,
  output logic [3:0] max_idx
);
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  localparam logic [3:0] LAST = 4'(N - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [2:0] run_max;
  logic [3:0] run_idx;
  logic [2:0] sel_max;
  logic       sel_gt;
  logic       accept;
  logic       last;

  assign accept = (state == S_COLLECT) && in_valid;
  assign last   = (cnt == LAST);

  max3_sel u_sel (
    .a    (run_max),
    .b    (in_data),
    .max  (sel_max),
    .b_gt (sel_gt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_COLLECT;
      S_COLLECT: if (accept && last) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_COLLECT);
    busy     = (state == S_COLLECT) || (state == S_DONE);
    done     = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      run_max <= '0;
      run_idx <= '0;
      max_out <= '0;
      max_idx <= '0;
    end else begin
      if (state == S_IDLE && start) cnt <= '0;
      if (accept) begin
        cnt <= cnt + 4'd1;
        if (cnt == 4'd0) begin
          run_max <= in_data;
          run_idx <= '0;
        end else if (sel_gt) begin
          run_max <= in_data;
          run_idx <= cnt;
        end
        // final sample goes straight into the result so it is not lost
        if (last) begin
          max_out <= sel_max;
          max_idx <= sel_gt ? cnt : run_idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_max_seq_ctrl.sv
// Directed bench for max_seq_ctrl with N=4 and hand-computed frame results.
module tb_max_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [2:0] in_data;
  logic       in_ready, busy, done;
  logic [2:0] max_out;
  logic [3:0] max_idx;

  int nvec = 0;
  int nerr = 0;

  max_seq_ctrl #(.N(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .max_out  (max_out),
    .max_idx  (max_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [2:0] s0, input logic [2:0] s1,
                           input logic [2:0] s2, input logic [2:0] s3,
                           input int gap, input bit poke_start,
                           input logic [2:0] emax, input logic [3:0] eidx);
    logic [2:0] s [4];
    s = '{s0, s1, s2, s3};
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("collect_ready", {7'd0, in_ready}, 8'd1);
    chk("collect_busy",  {7'd0, busy},     8'd1);
    for (int i = 0; i < 4; i++) begin
      start    = poke_start;
      in_valid = 1'b1;
      in_data  = s[i];
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
      if (i < 3) begin
        chk("mid_done",  {7'd0, done},     8'd0);
        chk("mid_ready", {7'd0, in_ready}, 8'd1);
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("gap_ready", {7'd0, in_ready}, 8'd1);
          chk("gap_done",  {7'd0, done},     8'd0);
        end
      end
    end
    chk("done_pulse", {7'd0, done},     8'd1);
    chk("done_busy",  {7'd0, busy},     8'd1);
    chk("done_ready", {7'd0, in_ready}, 8'd0);
    chk("max_out",    {5'd0, max_out},  {5'd0, emax});
    chk("max_idx",    {4'd0, max_idx},  {4'd0, eidx});
    start = poke_start;
    tick();
    start = 1'b0;
    chk("post_done", {7'd0, done}, 8'd0);
    chk("post_busy", {7'd0, busy}, 8'd0);
    chk("post_max",  {5'd0, max_out}, {5'd0, emax});
    tick();
    chk("idle_busy", {7'd0, busy}, 8'd0);
    chk("idle_done", {7'd0, done}, 8'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 3'b000;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_busy",  {7'd0, busy},     8'd0);
    chk("rst_done",  {7'd0, done},     8'd0);
    chk("rst_max",   {5'd0, max_out},  8'd0);
    chk("rst_idx",   {4'd0, max_idx},  8'd0);

    // 1, -2, 3, 0 -> +3 at index 2
    run_frame(3'b001, 3'b110, 3'b011, 3'b000, 0, 1'b0, 3'b011, 4'd2);

    // reset after two samples of a frame aborts it and clears the result
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 3'b010; tick();
    in_data = 3'b001; tick();
    in_valid = 1'b0;
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    chk("mrst_ready", {7'd0, in_ready}, 8'd0);
    chk("mrst_busy",  {7'd0, busy},     8'd0);
    chk("mrst_done",  {7'd0, done},     8'd0);
    chk("mrst_max",   {5'd0, max_out},  8'd0);
    chk("mrst_idx",   {4'd0, max_idx},  8'd0);
    tick();
    chk("mrst_idle", {7'd0, busy}, 8'd0);

    // all negative: -3, -1, -4, -2 -> -1 at index 1
    run_frame(3'b101, 3'b111, 3'b100, 3'b110, 0, 1'b0, 3'b111, 4'd1);

    // ties with 3-cycle gaps: 2, 2, -4, 2 -> 2 at index 0
    run_frame(3'b010, 3'b010, 3'b100, 3'b010, 3, 1'b0, 3'b010, 4'd0);

    // boundary with start poked through COLLECT/DONE: -4, -4, -4, 3 -> 3 at 3
    run_frame(3'b100, 3'b100, 3'b100, 3'b011, 0, 1'b1, 3'b011, 4'd3);
    tick();
    chk("no_extra_busy", {7'd0, busy}, 8'd0);
    chk("no_extra_done", {7'd0, done}, 8'd0);

    // hold: partial frame leaves previous result untouched
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 3'b111; tick();
    chk("hold_max1",  {5'd0, max_out}, 8'd3);
    chk("hold_done1", {7'd0, done},    8'd0);
    in_data = 3'b111; tick();
    in_valid = 1'b0;
    chk("hold_max2",  {5'd0, max_out}, 8'd3);
    chk("hold_idx2",  {4'd0, max_idx}, 8'd3);
    chk("hold_done2", {7'd0, done},    8'd0);
    tick();
    chk("hold_max3",  {5'd0, max_out}, 8'd3);
    in_valid = 1'b1; in_data = 3'b000; tick();
    chk("hold_done3", {7'd0, done}, 8'd0);
    in_data = 3'b001; tick();
    in_valid = 1'b0;
    // -1, -1, 0, 1 -> +1 at index 3
    chk("hold_final_done", {7'd0, done},    8'd1);
    chk("hold_final_max",  {5'd0, max_out}, 8'd1);
    chk("hold_final_idx",  {4'd0, max_idx}, 8'd3);
    tick();
    chk("hold_final_idle", {7'd0, busy}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
